// File: rtl/output_score_accumulator.sv
// ---------------------------------------------------------------------------
// output_score_accumulator
//
// Output-layer accumulation stage. Sums NUM_TERMS signed partial products per
// output neuron, applies ReLU plus unsigned saturation, and stores each
// neuron's score. Once all NUM_NEURONS scores are filled, the array is shown
// on neural_out with out_valid and held until out_ack.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   clear      synchronous frame abort; returns the block to its reset state
//   in_valid   in_data valid
//   in_ready   block accepts in_data (high while accumulating)
//   in_data    signed two's-complement partial product
//   out_valid  neural_out holds a complete frame
//   out_ack    downstream consumed the frame
//   neural_out per-digit unsigned scores, index = digit
//   busy       at least one term of the current frame has been accepted
// ---------------------------------------------------------------------------
module output_score_accumulator #(
    parameter int NUM_TERMS   = 64,
    parameter int NUM_NEURONS = 10,
    parameter int OUT_WIDTH   = 16,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic [OUT_WIDTH-1:0] neural_out [NUM_NEURONS-1:0],
    output logic                 busy
);

    localparam int TERM_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int IDX_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // Largest storable score, as a positive accumulator-width value.
    localparam logic signed [ACC_WIDTH-1:0] SCORE_MAX =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [0:0]                  state_reg;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic [TERM_W-1:0]           term_cnt_reg;
    logic [IDX_W-1:0]            neuron_idx_reg;
    logic                        busy_reg;
    logic [OUT_WIDTH-1:0]        score_reg [NUM_NEURONS-1:0];

    logic                        handshake;
    logic                        last_term;
    logic                        last_neuron;
    logic                        store_en;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic [OUT_WIDTH-1:0]        clamp_next;

    assign in_ready  = (state_reg == ST_ACCUM);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = busy_reg;

    assign handshake   = in_valid && in_ready;
    assign last_term   = (term_cnt_reg == TERM_W'(NUM_TERMS - 1));
    assign last_neuron = (neuron_idx_reg == IDX_W'(NUM_NEURONS - 1));
    // A clear on the same edge drops the term, so it must not store a score.
    assign store_en    = handshake && last_term && !clear;

    assign sum_next = acc_reg + {{(ACC_WIDTH-16){in_data[15]}}, in_data};

    // ReLU followed by saturation to the unsigned score range.
    always_comb begin
        clamp_next = sum_next[OUT_WIDTH-1:0];
        if (sum_next < 0) begin
            clamp_next = '0;
        end else if (sum_next > SCORE_MAX) begin
            clamp_next = '1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_ACCUM;
            acc_reg        <= '0;
            term_cnt_reg   <= '0;
            neuron_idx_reg <= '0;
            busy_reg       <= 1'b0;
        end else if (clear) begin
            state_reg      <= ST_ACCUM;
            acc_reg        <= '0;
            term_cnt_reg   <= '0;
            neuron_idx_reg <= '0;
            busy_reg       <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            if (out_ack) begin
                state_reg <= ST_ACCUM;
            end
        end else if (handshake) begin
            if (!last_term) begin
                acc_reg      <= sum_next;
                term_cnt_reg <= term_cnt_reg + 1'b1;
                busy_reg     <= 1'b1;
            end else begin
                acc_reg      <= '0;
                term_cnt_reg <= '0;
                if (last_neuron) begin
                    neuron_idx_reg <= '0;
                    busy_reg       <= 1'b0;
                    state_reg      <= ST_DONE;
                end else begin
                    neuron_idx_reg <= neuron_idx_reg + 1'b1;
                    busy_reg       <= 1'b1;
                end
            end
        end
    end

    // One score register per digit; each is only written on its own neuron's
    // final term, so old values persist until the next frame overwrites them.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_score
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    score_reg[gi] <= '0;
                end else if (clear) begin
                    score_reg[gi] <= '0;
                end else if (store_en && (neuron_idx_reg == IDX_W'(gi))) begin
                    score_reg[gi] <= clamp_next;
                end
            end
            assign neural_out[gi] = score_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_output_score_accumulator.sv
module tb_output_score_accumulator;

    localparam int NT = 64;
    localparam int NN = 10;
    localparam int FRAME = NT * NN;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ack = 1'b0;
    logic [15:0] neural_out [NN-1:0];
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: frame-level view (terms accepted so far in frame).
    bit     m_done;
    int     m_k;
    longint m_sum;
    int     m_exp [NN];

    output_score_accumulator dut (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ack(out_ack),
        .neural_out(neural_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int clamp(longint s);
        if (s < 0) return 0;
        if (s > 65535) return 65535;
        return int'(s);
    endfunction

    task automatic model_reset();
        m_done = 0;
        m_k = 0;
        m_sum = 0;
        for (int i = 0; i < NN; i++) m_exp[i] = 0;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compare();
        bit ok;
        string s;
        ok = (out_valid == m_done) && (in_ready == !m_done) && (busy == (m_k != 0));
        for (int i = 0; i < NN; i++) if (int'(neural_out[i]) != m_exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            s = "";
            for (int i = 0; i < NN; i++)
                s = {s, $sformatf(" %0d:%0h/%0h", i, neural_out[i], m_exp[i])};
            $display("FAIL cycle t=%0t ov=%0b/%0b ir=%0b/%0b busy=%0b/%0b scores(act/req)%s",
                     $time, out_valid, m_done, in_ready, !m_done, busy, (m_k != 0), s);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input bit v, input logic [15:0] d, input bit ack, input bit clr);
        in_valid = v; in_data = d; out_ack = ack; clear = clr;
        @(posedge clk);
        if (!n_rst || clr) begin
            model_reset();
        end else if (!m_done) begin
            if (v) begin
                m_sum += longint'($signed(d));
                m_k++;
                if (m_k % NT == 0) begin
                    m_exp[m_k / NT - 1] = clamp(m_sum);
                    m_sum = 0;
                    if (m_k == FRAME) begin
                        m_done = 1;
                        m_k = 0;
                    end
                end
            end
        end else if (ack) begin
            m_done = 0;
        end
        #1 compare();
    endtask

    function automatic logic [15:0] pat(input int p, input int n, input int t);
        case (p)
            0: begin
                if (n == 0) return 16'd31;
                if (n == 1) return 16'hFFFB;
                if (n == 2) return 16'h7FFF;
                return 16'(n);
            end
            1: return 16'd1;
            3: begin
                if (n == 0) return (t < NT-1) ? 16'h8000 : 16'h7FFF;
                if (n == 1) return (t < NT-1) ? 16'd1023 : 16'd1086;
                return 16'($urandom);
            end
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_frame(input int p, input bit stall);
        int acc = 0;
        int cyc = 0;
        bit v;
        while (acc < FRAME && cyc < 20000) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            step(v, pat(p, acc / NT, acc % NT), stall ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
            if (v) acc++;
            cyc++;
        end
        if (acc < FRAME) begin
            checks++; errors++;
            $display("FAIL frame_timeout accepted=%0d required=%0d", acc, FRAME);
        end else begin
            check_val("out_valid_after_last_term", int'(out_valid), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_plan_frame(input string tag);
        int req [NN] = '{16'h07C0, 0, 16'hFFFF, 192, 256, 320, 384, 448, 512, 576};
        for (int i = 0; i < NN; i++) begin
            check_val($sformatf("%s_model[%0d]", tag, i), m_exp[i], req[i]);
            check_val($sformatf("%s_dut[%0d]", tag, i), int'(neural_out[i]), req[i]);
        end
    endtask

    task automatic ack_frame();
        step(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset
        #2;
        check_val("reset_out_valid", int'(out_valid), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_score0", int'(neural_out[0]), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        check_val("reset_in_ready", int'(in_ready), 1);

        // Full frame, continuous
        run_frame(0, 1'b0);
        check_plan_frame("full");

        // Hold while DONE, then ack
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h1234, 1'b0, 1'b0);
            check_val("hold_in_ready", int'(in_ready), 0);
        end
        check_val("hold_score2", int'(neural_out[2]), 16'hFFFF);
        ack_frame();
        check_val("ack_out_valid", int'(out_valid), 0);
        check_val("ack_in_ready", int'(in_ready), 1);
        run_frame(1, 1'b0);
        for (int i = 0; i < NN; i++) check_val($sformatf("ones[%0d]", i), int'(neural_out[i]), 64);
        ack_frame();

        // Stalls with ignored out_ack in ACCUM
        run_frame(0, 1'b1);
        check_plan_frame("stall");
        ack_frame();

        // Async reset mid-frame, between edges
        for (int i = 0; i < 100; i++) step(1'b1, pat(0, i / NT, i % NT), 1'b0, 1'b0);
        #3 n_rst = 1'b0;
        #1;
        check_val("arst_out_valid", int'(out_valid), 0);
        check_val("arst_busy", int'(busy), 0);
        check_val("arst_score0", int'(neural_out[0]), 0);
        model_reset();
        step(1'b1, 16'h5555, 1'b0, 1'b0);
        n_rst = 1'b1;
        run_frame(0, 1'b0);
        check_plan_frame("arst");
        ack_frame();

        // Clear colliding with neuron0's final term
        for (int i = 0; i < NT - 1; i++) step(1'b1, 16'd31, 1'b0, 1'b0);
        step(1'b1, 16'd31, 1'b0, 1'b1);
        check_val("clear_score0", int'(neural_out[0]), 0);
        check_val("clear_score2", int'(neural_out[2]), 0);
        check_val("clear_busy", int'(busy), 0);
        for (int i = 0; i < NT; i++) step(1'b1, 16'd31, 1'b0, 1'b0);
        check_val("clear_refill_score0", int'(neural_out[0]), 16'h07C0);
        check_val("clear_refill_out_valid", int'(out_valid), 0);
        check_val("clear_refill_busy", int'(busy), 1);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Saturation boundaries
        run_frame(3, 1'b0);
        check_val("neg_sat_score0", int'(neural_out[0]), 0);
        check_val("exact_max_score1", int'(neural_out[1]), 65535);
        ack_frame();

        // Random frames with stalls and random ack delay
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 1'b1);
            for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b0);
            ack_frame();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_score_accumulator.md
Name: output_score_accumulator

Overview:
- Output-layer accumulation stage. Sits directly upstream of the seven-segment classifier stage.
- Consumes a serial stream of signed 16-bit partial products from the MAC, NUM_TERMS per output neuron, neuron 0 first.
- Accumulates each neuron's sum, applies ReLU plus unsigned saturation, and stores the result into a 10-entry score array.
- Once all neurons are filled, presents the complete array as neural_out with out_valid and holds it until acknowledged.

Parameters:
NUM_TERMS, 64, partial products per neuron (8x8 input image)
NUM_NEURONS, 10, output neurons (digits 0-9)
OUT_WIDTH, 16, width of each stored score, unsigned
ACC_WIDTH, 24, signed accumulator width; must be at least 16+clog2(NUM_TERMS)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset; one clock; reset is asynchronous and active-low
clear  input  1  synchronous frame abort/clear
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data
in_data  input  16  signed two's-complement partial product
out_valid  output  1  neural_out holds a complete frame
out_ack  input  1  downstream consumed the frame
neural_out  output  NUM_NEURONS x OUT_WIDTH  unpacked array [NUM_NEURONS-1:0] of [OUT_WIDTH-1:0] scores, index = digit
busy  output  1  at least one term of the current frame has been accepted

Behaviour:
- Reset (n_rst=0, async): state ACCUM, acc=0, term_cnt=0, neuron_idx=0, all neural_out=0, out_valid=0, busy=0. in_ready=1 after reset release.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Handshake is in_valid & in_ready on a rising edge. No handshake means no state change; arbitrary stalls are allowed.
- ACCUM handshake, term_cnt < NUM_TERMS-1: acc <= acc + sext(in_data); term_cnt++; busy <= 1.
- ACCUM handshake, term_cnt == NUM_TERMS-1:
  - sum = acc + sext(in_data).
  - neural_out[neuron_idx] <= clamp(sum), where clamp gives 0 if sum<0, 2^OUT_WIDTH-1 if sum>2^OUT_WIDTH-1, else sum[OUT_WIDTH-1:0].
  - acc <= 0; term_cnt <= 0.
- On that final term: if neuron_idx == NUM_NEURONS-1, then neuron_idx <= 0, busy <= 0, state <= DONE. Otherwise neuron_idx++.
- Latency: out_valid rises the cycle after the final (NUM_NEURONS*NUM_TERMS-th) handshake. Each neural_out entry updates the cycle after its neuron's last term.
- DONE:
  - neural_out is stable.
  - in_valid is ignored and no data is consumed.
  - out_ack=1 moves to ACCUM next cycle: out_valid 0, in_ready 1. neural_out keeps the old values until each entry is overwritten by the next frame.
- out_ack while in ACCUM is ignored.
- clear=1 (any state): next cycle is identical to reset state, including neural_out=0. clear has priority over a simultaneous handshake (that term is dropped) and over out_ack.
- Intermediate acc cannot overflow for NUM_TERMS=64 and ACC_WIDTH=24 (range ±2,097,152). No wrap handling is required beyond that.
- Async reset mid-frame discards all partial state immediately.

Test Plan:
- Full frame, continuous in_valid:
  - Stimulus: neuron0 64x 16'd31; neuron1 64x -5; neuron2 64x 16'h7FFF; neuron k (3..9) 64x k.
  - Required: neural_out = {0x07C0, 0, 0xFFFF, 192, 256, 320, 384, 448, 512, 576}.
  - out_valid rises exactly 1 cycle after the 640th handshake.
- Hold/ack:
  - Stimulus: in DONE, drive in_valid=1 with data 16'h1234 for 5 cycles, then out_ack=1 for 1 cycle.
  - Required: in_ready=0 and neural_out unchanged for those 5 cycles.
  - Next cycle after out_ack: out_valid=0, in_ready=1.
  - A following frame of all-1 terms yields 64 in every entry.
- Stalls:
  - Stimulus: same frame as the first test with in_valid toggling pseudo-randomly.
  - Required: identical neural_out; out_valid only after 640 accepted terms.
- Async reset mid-frame:
  - Stimulus: assert n_rst low after 100 terms, between clock edges.
  - Required: immediately out_valid=0, busy=0, neural_out all 0.
  - A fresh full frame afterwards matches the first test.
- Clear collision:
  - Stimulus: clear=1 on the same edge as the 64th term of neuron0 (value 16'd31).
  - Required: neural_out[0]=0, term_cnt=0, neuron_idx=0.
  - The next 64 terms of 31 give neural_out[0]=0x07C0.
- Negative saturation boundary:
  - Stimulus: neuron0 63x 16'h8000 followed by 16'h7FFF.
  - Required: neural_out[0]=0.
  - Stimulus: 64 terms summing to exactly 65535.
  - Required: neural_out[0]=0xFFFF without wrap.
